// File: rtl/invert_block_marshaller.sv
// invert_block_marshaller: buffers one 32-beat block for the inversion engine, then streams the results back out.
module invert_block_marshaller #(
    parameter int BEAT_W         = 128,
    parameter int NUM_BEATS      = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [BEAT_W-1:0] in_data,
    output logic              in_ready,
    output logic              start_function,
    output logic [BEAT_W-1:0] values [NUM_BEATS],
    input  logic [BEAT_W-1:0] inverted_values [NUM_BEATS],
    input  logic              done,
    output logic              out_valid,
    output logic [BEAT_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              timeout_err,
    output logic [15:0]       blocks_done
);
    localparam int IW = $clog2(NUM_BEATS);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] LAST = IW'(NUM_BEATS - 1);
    localparam logic [CW-1:0] CMAX = CW'(TIMEOUT_CYCLES - 1);
    typedef enum logic [1:0] {FILL, ARM, WAIT_DONE, DRAIN} state_t;
    state_t            r_state;
    logic [IW-1:0]     r_idx;
    logic [CW-1:0]     r_cnt;
    logic              r_live;
    logic              r_start;
    logic              r_tmo;
    logic [15:0]       r_blocks_done;
    logic [BEAT_W-1:0] r_vals [NUM_BEATS];
    logic [BEAT_W-1:0] r_res [NUM_BEATS];
    logic              w_in_fire;
    logic              w_out_fire;
    // r_live holds in_ready low until the first edge after reset release
    assign in_ready       = r_live && r_state == FILL;
    assign out_valid      = r_state == DRAIN;
    assign out_data       = r_res[r_idx];
    assign busy           = r_state != FILL || r_idx != '0;
    assign start_function = r_start;
    assign timeout_err    = r_tmo;
    assign blocks_done    = r_blocks_done;
    assign values         = r_vals;
    assign w_in_fire      = in_valid && in_ready;
    assign w_out_fire     = out_valid && out_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= FILL;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_live        <= 1'b0;
            r_start       <= 1'b0;
            r_tmo         <= 1'b0;
            r_blocks_done <= '0;
            for (int i = 0; i < NUM_BEATS; i++) begin
                r_vals[i] <= '0;
                r_res[i]  <= '0;
            end
        end else begin
            r_live <= 1'b1;
            case (r_state)
                FILL: if (w_in_fire) begin
                    r_vals[r_idx] <= in_data;
                    r_idx         <= r_idx == LAST ? '0 : r_idx + 1'b1;
                    if (r_idx == LAST) r_state <= ARM;
                end
                // a done still high from the previous block must drop before we start
                ARM: if (!done) begin
                    r_state <= WAIT_DONE;
                    r_start <= 1'b1;
                    r_cnt   <= '0;
                end
                WAIT_DONE: if (done) begin
                    r_res   <= inverted_values;
                    r_start <= 1'b0;
                    r_state <= DRAIN;
                end else if (r_cnt == CMAX) begin
                    r_tmo   <= 1'b1;
                    r_start <= 1'b0;
                    r_state <= FILL;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                DRAIN: if (w_out_fire) begin
                    r_idx <= r_idx == LAST ? '0 : r_idx + 1'b1;
                    if (r_idx == LAST) begin
                        r_state       <= FILL;
                        r_blocks_done <= r_blocks_done + 16'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_invert_block_marshaller.sv
// tb_invert_block_marshaller: directed scenarios for the block marshaller with a simple engine model.
module tb_invert_block_marshaller;
    localparam int BW = 128;
    localparam int NB = 32;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [BW-1:0] in_data = '0;
    logic          in_ready;
    logic          start_function;
    logic [BW-1:0] values [NB];
    logic [BW-1:0] inverted_values [NB];
    logic          done = 1'b0;
    logic          out_valid;
    logic [BW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          timeout_err;
    logic [15:0]   blocks_done;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    invert_block_marshaller dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .start_function(start_function), .values(values), .inverted_values(inverted_values),
        .done(done), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .timeout_err(timeout_err), .blocks_done(blocks_done)
    );

    // engine model: every 16b pixel p becomes 255 - p
    always_comb begin
        for (int i = 0; i < NB; i++)
            for (int j = 0; j < 8; j++)
                inverted_values[i][j*16 +: 16] = 16'd255 - values[i][j*16 +: 16];
    end

    function automatic logic [BW-1:0] mk_beat(input int k, input int base);
        logic [BW-1:0] b;
        for (int j = 0; j < 8; j++) b[j*16 +: 16] = 16'(base + k * 8 + j);
        return b;
    endfunction

    function automatic logic [BW-1:0] exp_beat(input int k, input int base);
        logic [BW-1:0] b;
        for (int j = 0; j < 8; j++) b[j*16 +: 16] = 16'(255 - (base + k * 8 + j));
        return b;
    endfunction

    task automatic send_beats(input int first, input int n, input int base);
        for (int k = first; k < first + n; k++) begin
            int t = 0;
            while (in_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
            total++;
            if (in_ready !== 1'b1) $display("FAIL in_ready_wait beat %0d: in_ready=%b want 1", k, in_ready);
            else passed++;
            in_valid = 1'b1;
            in_data  = mk_beat(k, base);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_engine(input bit hold);
        int t = 0;
        while (start_function !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        total++;
        if (start_function !== 1'b1) $display("FAIL engine_start: start_function=%b want 1", start_function);
        else passed++;
        done = 1'b1;
        @(negedge clk);
        total++;
        if (start_function !== 1'b0) $display("FAIL start_drop: start_function=%b want 0", start_function);
        else passed++;
        if (!hold) done = 1'b0;
    endtask

    task automatic recv_block(input int base, input int pct);
        int got = 0;
        int t = 0;
        while (got < NB && t < 3000) begin
            out_ready = ($urandom_range(99) < pct);
            if (out_valid === 1'b1) begin
                total++;
                if (out_data !== exp_beat(got, base)) $display("FAIL out_data beat %0d: got %h want %h", got, out_data, exp_beat(got, base));
                else passed++;
                total++;
                if (in_ready !== 1'b0) $display("FAIL in_ready_in_drain beat %0d: got %b want 0", got, in_ready);
                else passed++;
                if (out_ready) got++;
            end
            @(negedge clk);
            t++;
        end
        out_ready = 1'b0;
        total++;
        if (got != NB) $display("FAIL beat_count: got %0d want %0d", got, NB);
        else passed++;
        total++;
        if (out_valid !== 1'b0) $display("FAIL extra_beat: out_valid=%b want 0", out_valid);
        else passed++;
    endtask

    task automatic check_blocks(input logic [15:0] want);
        total++;
        if (blocks_done !== want) $display("FAIL blocks_done: got %h want %h", blocks_done, want);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else passed++;
        total++; if (start_function !== 1'b0) $display("FAIL rst_start: got %b want 0", start_function); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_data !== '0) $display("FAIL rst_out_data: got %h want 0", out_data); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        total++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout_err: got %b want 0", timeout_err); else passed++;
        check_blocks(16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b want 1", in_ready); else passed++;
        send_beats(0, 10, 0);
        total++; if (busy !== 1'b1) $display("FAIL busy_mid_fill: got %b want 1", busy); else passed++;
        total++; if (values[3] !== mk_beat(3, 0)) $display("FAIL values3: got %h want %h", values[3], mk_beat(3, 0)); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL midrst_in_ready: got %b want 0", in_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passed++;
        total++; if (values[3] !== '0) $display("FAIL midrst_values3: got %h want 0", values[3]); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_beats(0, 31, 16'h40);
        repeat (4) @(negedge clk);
        total++; if (start_function !== 1'b0) $display("FAIL partial_no_start: got %b want 0", start_function); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL partial_busy: got %b want 1", busy); else passed++;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        send_beats(0, NB, 0);
        total++; if (start_function !== 1'b0) $display("FAIL arm_start: got %b want 0", start_function); else passed++;
        @(negedge clk);
        total++; if (start_function !== 1'b1) $display("FAIL start_latency: got %b want 1", start_function); else passed++;
        run_engine(1'b0);
        recv_block(0, 100);
        check_blocks(16'h0001);
        total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready: got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_backpressure();
        send_beats(0, NB, 16'h100);
        run_engine(1'b0);
        recv_block(16'h100, 30);
        check_blocks(16'h0002);
    endtask

    task automatic test_stale_done();
        send_beats(0, NB, 16'h200);
        run_engine(1'b1);
        recv_block(16'h200, 100);
        send_beats(0, NB, 16'h300);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (start_function !== 1'b0) $display("FAIL stale_hold cycle %0d: got %b want 0", i, start_function);
            else passed++;
            @(negedge clk);
        end
        done = 1'b0;
        @(negedge clk);
        total++; if (start_function !== 1'b1) $display("FAIL stale_release: got %b want 1", start_function); else passed++;
        run_engine(1'b0);
        recv_block(16'h300, 100);
        check_blocks(16'h0004);
    endtask

    task automatic test_timeout();
        int t = 0;
        int hi = 0;
        bit saw_ov = 1'b0;
        send_beats(0, NB, 16'h400);
        while (start_function !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        while (start_function === 1'b1 && hi < 400) begin
            if (out_valid === 1'b1) saw_ov = 1'b1;
            hi++;
            @(negedge clk);
        end
        total++; if (hi != 256) $display("FAIL start_high_cycles: got %0d want 256", hi); else passed++;
        total++; if (timeout_err !== 1'b1) $display("FAIL timeout_err: got %b want 1", timeout_err); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL tmo_in_ready: got %b want 1", in_ready); else passed++;
        total++; if ((saw_ov || out_valid === 1'b1) !== 1'b0) $display("FAIL tmo_out_valid: got 1 want 0"); else passed++;
        send_beats(0, NB, 16'h500);
        run_engine(1'b0);
        recv_block(16'h500, 100);
        check_blocks(16'h0005);
        total++; if (timeout_err !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", timeout_err); else passed++;
    endtask

    task automatic test_wrap();
        force dut.r_blocks_done = 16'hFFFF;
        @(negedge clk);
        release dut.r_blocks_done;
        @(negedge clk);
        check_blocks(16'hFFFF);
        send_beats(0, NB, 16'h600);
        run_engine(1'b0);
        recv_block(16'h600, 100);
        check_blocks(16'h0000);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_backpressure();
        test_stale_done();
        test_timeout();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
        $fatal(1, "watchdog");
    end
endmodule
